// File: rtl/control_unit.sv
// control_unit: registered RV32I main decoder with one-cycle latency.
// Defining CONTROL_ILLEGAL_CNT_EN adds a saturating IllegalCount output.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic [1:0] ALUOp,
  output logic       Illegal
`ifdef CONTROL_ILLEGAL_CNT_EN
  ,
  output logic [7:0] IllegalCount
`endif
);
  // {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, Illegal}
  logic [9:0] d, q;
  always_comb begin
    d = 10'b0_0_0_0_0_0_0_00_1;
    case (Opcode)
      7'b0110011: d = 10'b0_0_1_0_0_0_0_10_0;
      7'b0000011: d = 10'b1_1_1_1_0_0_0_00_0;
      7'b0100011: d = 10'b1_0_0_0_1_0_0_00_0;
      7'b1100011: d = 10'b0_0_0_0_0_1_0_01_0;
      7'b0010011: d = 10'b1_0_1_0_0_0_0_11_0;
      7'b1101111: d = 10'b0_0_1_0_0_0_1_00_0;
      7'b1100111: d = 10'b1_0_1_0_0_0_1_00_0;
      default:    d = 10'b0_0_0_0_0_0_0_00_1;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= d;
  assign {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, Illegal} = q;
`ifdef CONTROL_ILLEGAL_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) IllegalCount <= '0;
    else if (d[0] && IllegalCount != 8'hff) IllegalCount <= IllegalCount + 8'd1;
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized and directed check of control_unit against a rule-based decode model.
module tb_control_unit;
  logic       clk = 0;
  logic       rst = 1;
  logic [6:0] Opcode = 7'b0110011;
  logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, Illegal;
  logic [1:0] ALUOp;
  logic [9:0] dut, exp_v;
  int         errors = 0;
  int         checks = 0;
  logic [6:0] legal_ops [7] = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h6f, 7'h67};
`ifdef CONTROL_ILLEGAL_CNT_EN
  logic [7:0] IllegalCount;
  int         exp_cnt;
`endif

  control_unit u_dut (
    .clk(clk), .rst(rst), .Opcode(Opcode),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .ALUOp(ALUOp), .Illegal(Illegal)
`ifdef CONTROL_ILLEGAL_CNT_EN
    , .IllegalCount(IllegalCount)
`endif
  );

  always #5 clk = ~clk;
  assign dut = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, Illegal};

  function automatic logic [9:0] model(input logic [6:0] op);
    bit r  = op == 7'h33;
    bit ld = op == 7'h03;
    bit st = op == 7'h23;
    bit br = op == 7'h63;
    bit ia = op == 7'h13;
    bit jl = op == 7'h6f;
    bit jr = op == 7'h67;
    bit ok = r | ld | st | br | ia | jl | jr;
    logic [1:0] aop = r ? 2'd2 : br ? 2'd1 : ia ? 2'd3 : 2'd0;
    return {ld | st | ia | jr, ld, r | ld | ia | jl | jr, ld, st, br, jl | jr, aop, !ok};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      exp_v = '0;
`ifdef CONTROL_ILLEGAL_CNT_EN
      exp_cnt = 0;
`endif
    end else begin
      exp_v = model(Opcode);
`ifdef CONTROL_ILLEGAL_CNT_EN
      if (exp_v[0] && exp_cnt < 255) exp_cnt++;
`endif
    end

  always @(negedge clk) begin
    check("cycle", dut, exp_v);
    check("exclusive", {8'd0, MemRead & MemWrite, Branch & Jump}, 10'd0);
`ifdef CONTROL_ILLEGAL_CNT_EN
    check("count", {2'b0, IllegalCount}, exp_cnt[9:0]);
`endif
  end

  task automatic step(input logic [6:0] op);
    @(posedge clk);
    #2 Opcode = op;
  endtask

  task automatic pin(input string name, input logic [9:0] req);
    @(posedge clk);
    #1 check(name, dut, req);
  endtask

  initial begin
    #1 check("reset_init", dut, 10'd0);
    @(negedge clk);
    rst = 0;
    step(7'h03);
    pin("pre_reset_load", 10'b1_1_1_1_0_0_0_00_0);
    #2 rst = 1;
    #1 check("async_reset", dut, 10'd0);
    Opcode = 7'b0110011;
    @(negedge clk);
    rst = 0;
    pin("rtype", 10'b0_0_1_0_0_0_0_10_0);
    #1 Opcode = 7'h03;
    pin("load", 10'b1_1_1_1_0_0_0_00_0);
    #1 Opcode = 7'h23;
    pin("store", 10'b1_0_0_0_1_0_0_00_0);
    #1 Opcode = 7'h63;
    pin("branch", 10'b0_0_0_0_0_1_0_01_0);
    #1 Opcode = 7'h13;
    pin("ialu", 10'b1_0_1_0_0_0_0_11_0);
    #1 Opcode = 7'h6f;
    pin("jal", 10'b0_0_1_0_0_0_1_00_0);
    #1 Opcode = 7'h67;
    pin("jalr", 10'b1_0_1_0_0_0_1_00_0);
    #1 Opcode = 7'h00;
    pin("ill_zero", 10'b0_0_0_0_0_0_0_00_1);
    #1 Opcode = 7'h7f;
    pin("ill_ones", 10'b0_0_0_0_0_0_0_00_1);
    #1 Opcode = 7'h37;
    pin("ill_lui", 10'b0_0_0_0_0_0_0_00_1);
`ifdef CONTROL_ILLEGAL_CNT_EN
    check("count3", {2'b0, IllegalCount}, 10'd3);
`endif
    #1 Opcode = 7'h33;
    pin("lat_r", 10'b0_0_1_0_0_0_0_10_0);
    #2 Opcode = 7'h23;
    #1 check("lat_hold", dut, 10'b0_0_1_0_0_0_0_10_0);
    pin("lat_store", 10'b1_0_0_0_1_0_0_00_0);
    for (int i = 0; i < 200; i++)
      step($urandom_range(1) ? legal_ops[$urandom_range(6)] : 7'($urandom));
    for (int i = 0; i < 300; i++) step(7'h7f);
    pin("sat_ill", 10'b0_0_0_0_0_0_0_00_1);
`ifdef CONTROL_ILLEGAL_CNT_EN
    check("sat255", {2'b0, IllegalCount}, 10'd255);
`endif
    #2 rst = 1;
    #1 check("reset_after_sat", dut, 10'd0);
`ifdef CONTROL_ILLEGAL_CNT_EN
    check("count_clr", {2'b0, IllegalCount}, 10'd0);
`endif
    @(negedge clk);
    rst = 0;
    Opcode = 7'h63;
    pin("post_reset_branch", 10'b0_0_0_0_0_1_0_01_0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
